core_writeback: RTL and testbench
=================================

# core_writeback

Writeback stage of the i2d core: the producing end of the `wb_data` path that the operand mux consumes. It accepts one result per instruction from EX and selects between the ALU result, the link address (PC+4) and load data. For loads it waits for the data memory response, extracts and extends the addressed byte or halfword, and drives the register-file write port. It also drives a load-pending tag for hazard and forwarding logic.

## Interface
- `DW`, 32, datapath width
- `RW`, 5, register index width

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `ex_valid`  in  1  EX presents a result this cycle
- `ex_ready`  out  1  writeback accepts EX result; transfer occurs on `ex_valid & ex_ready`
- `ex_we`  in  1  instruction writes `ex_rd`
- `ex_rd`  in  RW  destination register
- `ex_sel`  in  2  source select: `CORE_WB_SEL_ALU`, `CORE_WB_SEL_LOAD`, `CORE_WB_SEL_LINK`; the fourth code writes nothing
- `ex_alu`  in  DW  ALU result
- `ex_pc`  in  DW  instruction PC
- `ex_ldsize`  in  2  `CORE_LDSIZE_B`=00, `_H`=01, `_W`=10; 11 is treated as word
- `ex_ldsign`  in  1  1 = sign-extend, 0 = zero-extend
- `ex_addr_lo`  in  2  load byte offset
- `dm_rvalid`  in  1  load data valid
- `dm_rdata`  in  DW  load data
- `wb_we`  out  1  register-file write strobe, single-cycle pulse
- `wb_rd`  out  RW  write index
- `wb_data`  out  DW  write data
- `ld_busy`  out  1  load outstanding
- `ld_rd`  out  RW  destination of the outstanding load

## Operation
- FSM states: IDLE, LOAD_WAIT.
- `ex_ready = rst & (state == IDLE)`. It is combinational.
- IDLE, on transfer:
  - ALU: register `wb_data = ex_alu`.
  - LINK: register `wb_data = ex_pc + 4`, truncated to DW, wraps.
  - In both cases, register `wb_rd = ex_rd` and `wb_we = ex_we & (ex_rd != 0)`.
  - LOAD: capture rd, we, size, sign and offset. Go to LOAD_WAIT.
- LOAD_WAIT:
  - `ld_busy = 1` and `ld_rd` = captured rd.
  - On `dm_rvalid`: register the extracted data, set `wb_we = captured_we & (rd != 0)`, return to IDLE.
  - A load to r0 still waits for its data but produces no write.
- Extraction is little-endian:
  - Byte: lane = `addr_lo`.
  - Half: `addr_lo[1]` selects the upper half; `addr_lo[0]` is ignored.
  - Word: data passes unchanged.
  - Bits above the selected field are sign- or zero-extended per `ex_ldsign`.
- `dm_rvalid` in IDLE is ignored: no write, no state change.
- Unused `ex_sel` code: transfer completes, `wb_we = 0`.
- `wb_we` deasserts the cycle after every pulse. `wb_data` and `wb_rd` hold their last value when `wb_we = 0`.

## Timing
- Reset while `rst = 0` at a clock edge:
  - state = IDLE.
  - `wb_we`, `wb_rd`, `wb_data`, `ld_busy` and `ld_rd` are all 0.
  - `ex_ready` is 0 while `rst` is low.
- ALU/LINK: transfer at edge N → `wb_we` high from edge N until edge N+1.
- Load: transfer at edge N → `ld_busy` high from edge N. `dm_rvalid` sampled at edge M > N → `wb_we` high from M to M+1, and `ld_busy` low from M. `ex_ready` rises from M.
- Memory returns data no earlier than the cycle after acceptance. `dm_rvalid` in the acceptance cycle is ignored.
- A new EX transfer and load completion never coincide, because `ex_ready = 0` throughout LOAD_WAIT. At most one write occurs per cycle.
- Reset mid-load abandons the load. A later `dm_rvalid` is ignored.
- Back-to-back ALU results: one write per cycle with zero bubbles.

## Structure
- Add `CORE_WB_SEL_*` and `CORE_LDSIZE_*` to `i2d_core_defines.v`.
- Sub-module `core_ldextract`: combinational lane select plus sign/zero extension. Inputs: data, size, sign, offset. Output: extended word.
- The FSM and output registers live in `core_writeback`.

## Test plan
- ALU: rd=3, alu=0x12345678, we=1 → next cycle `wb_we=1`, `wb_rd=3`, `wb_data=0x12345678`; the cycle after, `wb_we=0` with data held.
- LINK: pc=0xFFFFFFFC, rd=31 → `wb_data=0x00000000`, `wb_rd=31`.
- Load, byte, signed, offset 2, rdata 0x11803344 returned 3 cycles later:
  - while waiting: `ex_ready=0`, `ld_busy=1`, `ld_rd` correct;
  - then `wb_data=0xFFFFFF80`.
- Load, half, unsigned, offset 3, rdata 0x80011234 → `wb_data=0x00008001`. Word load, offset 1 → rdata unchanged.
- rd=0 ALU and rd=0 load → no `wb_we`. `dm_rvalid` pulse in IDLE → no write.
- `rst` low during LOAD_WAIT:
  - all outputs 0, state IDLE;
  - a subsequent `dm_rvalid` is ignored;
  - the next ALU transfer writes normally.

Source files
------------

// File: rtl/core_writeback_pkg.sv
// core_writeback_pkg: shared types and constants for the i2d writeback stage.
//   CORE_DW / CORE_RW   default datapath and register-index widths
//   wb_sel_e            EX result source select
//   ld_size_e           load access size
//   wb_state_e          writeback FSM states
package core_writeback_pkg;

   localparam int CORE_DW = 32;
   localparam int CORE_RW = 5;

   typedef enum logic [1:0] {
      CORE_WB_SEL_ALU  = 2'b00,
      CORE_WB_SEL_LOAD = 2'b01,
      CORE_WB_SEL_LINK = 2'b10,
      CORE_WB_SEL_NONE = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      CORE_LDSIZE_B  = 2'b00,
      CORE_LDSIZE_H  = 2'b01,
      CORE_LDSIZE_W  = 2'b10,
      CORE_LDSIZE_WX = 2'b11
   } ld_size_e;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_LOAD_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/core_writeback_if.sv
// core_writeback_if: bundles the EX handshake, data-memory response and
// register-file write port of the writeback stage.
//   master : EX / memory side (drives ex_*, dm_*; observes wb_*, ld_*)
//   slave  : writeback stage (drives ex_ready, wb_*, ld_*)
interface core_writeback_if
   import core_writeback_pkg::*;
   #(
      parameter int DW = CORE_DW,
      parameter int RW = CORE_RW
   );

   logic          ex_valid;
   logic          ex_ready;
   logic          ex_we;
   logic [RW-1:0] ex_rd;
   logic [1:0]    ex_sel;
   logic [DW-1:0] ex_alu;
   logic [DW-1:0] ex_pc;
   logic [1:0]    ex_ldsize;
   logic          ex_ldsign;
   logic [1:0]    ex_addr_lo;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          wb_we;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic          ld_busy;
   logic [RW-1:0] ld_rd;

   modport master (
      output ex_valid, ex_we, ex_rd, ex_sel, ex_alu, ex_pc,
             ex_ldsize, ex_ldsign, ex_addr_lo, dm_rvalid, dm_rdata,
      input  ex_ready, wb_we, wb_rd, wb_data, ld_busy, ld_rd
   );

   modport slave (
      input  ex_valid, ex_we, ex_rd, ex_sel, ex_alu, ex_pc,
             ex_ldsize, ex_ldsign, ex_addr_lo, dm_rvalid, dm_rdata,
      output ex_ready, wb_we, wb_rd, wb_data, ld_busy, ld_rd
   );

endinterface

// File: rtl/core_ldextract.sv
// core_ldextract: combinational little-endian lane select and extension of
// load data.
//   data   in  raw memory word
//   size   in  access size (B/H/W; the spare code behaves as W)
//   sign   in  1 = sign-extend, 0 = zero-extend
//   offset in  byte offset within the word
//   ext    out extended result
module core_ldextract
   import core_writeback_pkg::*;
   #(
      parameter int DW = CORE_DW
   ) (
      input  logic [DW-1:0] data,
      input  logic [1:0]    size,
      input  logic          sign,
      input  logic [1:0]    offset,
      output logic [DW-1:0] ext
   );

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte lane and halfword; offset[0] plays no part in halves.
   always_comb begin
      byte_s = data[7:0];
      half_s = data[15:0];
      case (offset)
         2'b00:   byte_s = data[7:0];
         2'b01:   byte_s = data[15:8];
         2'b10:   byte_s = data[23:16];
         2'b11:   byte_s = data[31:24];
         default: byte_s = data[7:0];
      endcase
      if (offset[1]) begin
         half_s = data[31:16];
      end else begin
         half_s = data[15:0];
      end
   end

   // Extend the selected field to the full datapath width.
   always_comb begin
      ext = data;
      case (size)
         CORE_LDSIZE_B: ext = {{(DW-8){sign & byte_s[7]}}, byte_s};
         CORE_LDSIZE_H: ext = {{(DW-16){sign & half_s[15]}}, half_s};
         default:       ext = data;
      endcase
   end

endmodule

// File: rtl/core_writeback.sv
// core_writeback: writeback stage. Accepts one EX result per instruction,
// selects ALU / link (PC+4) / load data, waits for the memory response on
// loads and drives the register-file write port plus a load-pending tag.
//   clk, rst  clock, synchronous active-low reset
//   bus       core_writeback_if.slave (EX handshake, dm response, wb/ld outputs)
module core_writeback
   import core_writeback_pkg::*;
   #(
      parameter int DW = CORE_DW,
      parameter int RW = CORE_RW
   ) (
      input logic            clk,
      input logic            rst,
      core_writeback_if.slave bus
   );

   localparam logic [DW-1:0] LINK_OFS = DW'(3'd4);
   localparam logic [RW-1:0] RD_ZERO  = {RW{1'b0}};

   wb_state_e     state_r, state_s;
   logic          wb_we_r, wb_we_s;
   logic [RW-1:0] wb_rd_r, wb_rd_s;
   logic [DW-1:0] wb_data_r, wb_data_s;
   logic [RW-1:0] cap_rd_r, cap_rd_s;
   logic          cap_we_r, cap_we_s;
   logic [1:0]    cap_size_r, cap_size_s;
   logic          cap_sign_r, cap_sign_s;
   logic [1:0]    cap_off_r, cap_off_s;
   logic          xfer_s;
   logic [DW-1:0] ld_ext_s;

   core_ldextract #(.DW(DW)) u_ldextract (
      .data   (bus.dm_rdata),
      .size   (cap_size_r),
      .sign   (cap_sign_r),
      .offset (cap_off_r),
      .ext    (ld_ext_s)
   );

   assign bus.ex_ready = rst & (state_r == WB_IDLE);
   assign xfer_s       = bus.ex_valid & bus.ex_ready;

   assign bus.wb_we    = wb_we_r;
   assign bus.wb_rd    = wb_rd_r;
   assign bus.wb_data  = wb_data_r;
   assign bus.ld_busy  = (state_r == WB_LOAD_WAIT);
   assign bus.ld_rd    = cap_rd_r;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= WB_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and next output/capture values; wb_we defaults low so every write is one cycle.
   always_comb begin
      state_s    = state_r;
      wb_we_s    = 1'b0;
      wb_rd_s    = wb_rd_r;
      wb_data_s  = wb_data_r;
      cap_rd_s   = cap_rd_r;
      cap_we_s   = cap_we_r;
      cap_size_s = cap_size_r;
      cap_sign_s = cap_sign_r;
      cap_off_s  = cap_off_r;
      case (state_r)
         WB_IDLE: begin
            if (xfer_s) begin
               case (bus.ex_sel)
                  CORE_WB_SEL_ALU: begin
                     wb_we_s   = bus.ex_we & (bus.ex_rd != RD_ZERO);
                     wb_rd_s   = bus.ex_rd;
                     wb_data_s = bus.ex_alu;
                  end
                  CORE_WB_SEL_LINK: begin
                     wb_we_s   = bus.ex_we & (bus.ex_rd != RD_ZERO);
                     wb_rd_s   = bus.ex_rd;
                     wb_data_s = bus.ex_pc + LINK_OFS;
                  end
                  CORE_WB_SEL_LOAD: begin
                     cap_rd_s   = bus.ex_rd;
                     cap_we_s   = bus.ex_we;
                     cap_size_s = bus.ex_ldsize;
                     cap_sign_s = bus.ex_ldsign;
                     cap_off_s  = bus.ex_addr_lo;
                     state_s    = WB_LOAD_WAIT;
                  end
                  default: begin
                     wb_we_s = 1'b0;
                  end
               endcase
            end else begin
               state_s = WB_IDLE;
            end
         end
         WB_LOAD_WAIT: begin
            if (bus.dm_rvalid) begin
               wb_we_s   = cap_we_r & (cap_rd_r != RD_ZERO);
               wb_rd_s   = cap_rd_r;
               wb_data_s = ld_ext_s;
               state_s   = WB_IDLE;
            end else begin
               state_s = WB_LOAD_WAIT;
            end
         end
         default: begin
            state_s = WB_IDLE;
         end
      endcase
   end

   // Output and load-capture registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_we_r    <= 1'b0;
         wb_rd_r    <= RD_ZERO;
         wb_data_r  <= {DW{1'b0}};
         cap_rd_r   <= RD_ZERO;
         cap_we_r   <= 1'b0;
         cap_size_r <= 2'b00;
         cap_sign_r <= 1'b0;
         cap_off_r  <= 2'b00;
      end else begin
         wb_we_r    <= wb_we_s;
         wb_rd_r    <= wb_rd_s;
         wb_data_r  <= wb_data_s;
         cap_rd_r   <= cap_rd_s;
         cap_we_r   <= cap_we_s;
         cap_size_r <= cap_size_s;
         cap_sign_r <= cap_sign_s;
         cap_off_r  <= cap_off_s;
      end
   end

endmodule

// File: tb/tb_core_writeback.sv
// tb_core_writeback: directed and randomized bench for core_writeback with a
// transaction-level reference model.
module tb_core_writeback;
   import core_writeback_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   core_writeback_if bus ();

   core_writeback dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   logic        m_busy;
   logic [4:0]  m_p_rd;
   logic        m_p_we;
   logic [1:0]  m_p_size;
   logic        m_p_sign;
   logic [1:0]  m_p_off;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Load extraction from arithmetic on the word: shift the field down, mask, extend.
   function automatic logic [31:0] ref_extract(input logic [31:0] d, input logic [1:0] size,
                                               input logic sign, input logic [1:0] off);
      int          nbits;
      int          shift;
      logic [31:0] mask;
      logic [31:0] f;
      if (size == 2'b00) begin
         nbits = 8;
         shift = 8 * int'(off);
      end else if (size == 2'b01) begin
         nbits = 16;
         shift = off[1] ? 16 : 0;
      end else begin
         return d;
      end
      mask = (32'h1 << nbits) - 32'h1;
      f    = (d >> shift) & mask;
      if (sign && f[nbits-1]) f = f | ~mask;
      return f;
   endfunction

   // One cycle: drive at negedge, check ex_ready, clock, update model, check outputs.
   task automatic step(input logic r, input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [1:0] size, input logic sign, input logic [1:0] off,
                       input logic rv, input logic [31:0] rdata);
      logic xfer;
      @(negedge clk);
      rst            = r;
      bus.ex_valid   = v;
      bus.ex_we      = we;
      bus.ex_rd      = rd;
      bus.ex_sel     = sel;
      bus.ex_alu     = alu;
      bus.ex_pc      = pc;
      bus.ex_ldsize  = size;
      bus.ex_ldsign  = sign;
      bus.ex_addr_lo = off;
      bus.dm_rvalid  = rv;
      bus.dm_rdata   = rdata;
      #1;
      check("ex_ready", {31'd0, bus.ex_ready}, {31'd0, r & ~m_busy});
      xfer = r & v & ~m_busy;
      @(posedge clk);
      if (!r) begin
         m_busy = 1'b0;
         m_we   = 1'b0;
         m_rd   = 5'd0;
         m_data = 32'd0;
         m_p_rd = 5'd0;
      end else begin
         m_we = 1'b0;
         if (xfer) begin
            if (sel == 2'b00 || sel == 2'b10) begin
               m_we   = we && (rd != 5'd0);
               m_rd   = rd;
               m_data = (sel == 2'b00) ? alu : pc + 32'd4;
            end else if (sel == 2'b01) begin
               m_busy   = 1'b1;
               m_p_rd   = rd;
               m_p_we   = we;
               m_p_size = size;
               m_p_sign = sign;
               m_p_off  = off;
            end
         end else if (m_busy && rv) begin
            m_busy = 1'b0;
            m_we   = m_p_we && (m_p_rd != 5'd0);
            m_rd   = m_p_rd;
            m_data = ref_extract(rdata, m_p_size, m_p_sign, m_p_off);
         end
      end
      #1;
      check("wb_we", {31'd0, bus.wb_we}, {31'd0, m_we});
      check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, m_rd});
      check("wb_data", bus.wb_data, m_data);
      check("ld_busy", {31'd0, bus.ld_busy}, {31'd0, m_busy});
      if (m_busy || !r) check("ld_rd", {27'd0, bus.ld_rd}, {27'd0, m_p_rd});
   endtask

   task automatic idle(input logic rv, input logic [31:0] rdata);
      step(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 2'b00, rv, rdata);
   endtask

   initial begin
      m_busy = 1'b0; m_p_rd = 5'd0; m_p_we = 1'b0; m_p_size = 2'b00;
      m_p_sign = 1'b0; m_p_off = 2'b00; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;

      // reset
      step(1'b0, 1'b1, 1'b1, 5'd7, 2'b00, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("rst_wb_data", bus.wb_data, 32'd0);

      // ALU write, then hold
      step(1'b1, 1'b1, 1'b1, 5'd3, 2'b00, 32'h12345678, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("alu_we", {31'd0, bus.wb_we}, 32'd1);
      check("alu_data", bus.wb_data, 32'h12345678);
      idle(1'b0, 32'd0);
      check("alu_hold_we", {31'd0, bus.wb_we}, 32'd0);
      check("alu_hold_data", bus.wb_data, 32'h12345678);

      // LINK wraps
      step(1'b1, 1'b1, 1'b1, 5'd31, 2'b10, 32'd0, 32'hFFFFFFFC, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("link_data", bus.wb_data, 32'h00000000);
      check("link_rd", {27'd0, bus.wb_rd}, 32'd31);

      // byte signed offset 2, data three cycles after acceptance
      step(1'b1, 1'b1, 1'b1, 5'd9, 2'b01, 32'd0, 32'd0, 2'b00, 1'b1, 2'b10, 1'b0, 32'd0);
      idle(1'b0, 32'd0);
      check("lb_wait_busy", {31'd0, bus.ld_busy}, 32'd1);
      check("lb_wait_rd", {27'd0, bus.ld_rd}, 32'd9);
      idle(1'b0, 32'd0);
      idle(1'b1, 32'h11803344);
      check("lb_data", bus.wb_data, 32'hFFFFFF80);

      // half unsigned offset 3; rvalid in the acceptance cycle is ignored
      step(1'b1, 1'b1, 1'b1, 5'd4, 2'b01, 32'd0, 32'd0, 2'b01, 1'b0, 2'b11, 1'b1, 32'hAAAAAAAA);
      idle(1'b1, 32'h80011234);
      check("lhu_data", bus.wb_data, 32'h00008001);

      // word load offset 1
      step(1'b1, 1'b1, 1'b1, 5'd5, 2'b01, 32'd0, 32'd0, 2'b10, 1'b1, 2'b01, 1'b0, 32'd0);
      idle(1'b1, 32'h89ABCDEF);
      check("lw_data", bus.wb_data, 32'h89ABCDEF);

      // r0 targets, spare select and stray rvalid produce no write
      step(1'b1, 1'b1, 1'b1, 5'd0, 2'b00, 32'h55555555, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("r0_alu_we", {31'd0, bus.wb_we}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 5'd0, 2'b01, 32'd0, 32'd0, 2'b10, 1'b0, 2'b00, 1'b0, 32'd0);
      idle(1'b1, 32'h77777777);
      check("r0_load_we", {31'd0, bus.wb_we}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 5'd6, 2'b11, 32'h66666666, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      idle(1'b1, 32'h12121212);
      check("idle_rvalid_we", {31'd0, bus.wb_we}, 32'd0);

      // reset mid-load
      step(1'b1, 1'b1, 1'b1, 5'd12, 2'b01, 32'd0, 32'd0, 2'b10, 1'b0, 2'b00, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("rst_load_busy", {31'd0, bus.ld_busy}, 32'd0);
      idle(1'b1, 32'h34343434);
      check("rst_load_ignored", {31'd0, bus.wb_we}, 32'd0);
      step(1'b1, 1'b1, 1'b1, 5'd2, 2'b00, 32'hCAFEF00D, 32'd0, 2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
      check("post_rst_alu", bus.wb_data, 32'hCAFEF00D);

      // back-to-back ALU writes
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1, 5'(i + 1), 2'b00, 32'(i * 32'h01010101), 32'd0,
              2'b00, 1'b0, 2'b00, 1'b0, 32'd0);
         check("b2b_we", {31'd0, bus.wb_we}, 32'd1);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), 1'($urandom),
              5'($urandom), 2'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom),
              2'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
